// File: rtl/e10_mon_pkg.sv
// Shared types and constants for the e10 response monitor.
package e10_mon_pkg;
  localparam int unsigned Y_W       = 13;
  localparam int unsigned SIG_W     = 16;
  localparam int unsigned EVT_CNT_W = 16;
  localparam logic [SIG_W-1:0] POLY_DEF = 16'h1021;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  // Event-FIFO entry layout for the default cycle-index width.
  typedef struct packed {
    logic [EVT_CNT_W-1:0] cyc_idx;
    logic [Y_W-1:0]       y;
  } evt_t;
endpackage

// File: rtl/e10_evt_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and registered valid/full flags.
module e10_evt_fifo #(
  parameter int unsigned W     = 29,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, full_q;
  logic          do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & valid_q;
  assign do_push = push_i & (~full_q | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign count_o = count_q;
endmodule

// File: rtl/e10_resp_monitor.sv
// Capture stage for the e10 controller: MISR signature, activity mask,
// all-zero watchdog and change-event logging over a programmed window.
module e10_resp_monitor
  import e10_mon_pkg::*;
#(
  parameter int unsigned      CNT_W      = 16,
  parameter int unsigned      DEPTH      = 8,
  parameter logic [SIG_W-1:0] POLY       = POLY_DEF,
  parameter int unsigned      ZERO_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Y_W-1:0]             y_in,
  input  logic                       start,
  input  logic                       clear,
  input  logic [CNT_W-1:0]           win_len,
  output logic                       busy,
  output logic                       done,
  output logic [SIG_W-1:0]           signature,
  output logic [Y_W-1:0]             ever_high,
  output logic                       zero_alarm,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [CNT_W+Y_W-1:0]       evt_data,
  output logic                       evt_ovf,
  output logic [$clog2(DEPTH+1)-1:0] evt_count
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d, cyc_idx_q, cyc_idx_d, zero_run_q, zero_run_d;
  logic [Y_W-1:0]   prev_q, prev_d, ever_high_q, ever_high_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             zero_alarm_q, zero_alarm_d, evt_ovf_q, evt_ovf_d;
  logic             busy_q, done_q;
  logic             push, flush, pop, fifo_full;

  assign pop = evt_valid & evt_ready;

  always_comb begin
    state_d      = state_q;
    win_len_d    = win_len_q;
    cyc_idx_d    = cyc_idx_q;
    zero_run_d   = zero_run_q;
    prev_d       = prev_q;
    ever_high_d  = ever_high_q;
    sig_d        = sig_q;
    zero_alarm_d = zero_alarm_q;
    evt_ovf_d    = evt_ovf_q;
    push         = 1'b0;
    flush        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = (win_len == '0) ? DONE : CAPTURE;
          win_len_d    = win_len;
          cyc_idx_d    = '0;
          zero_run_d   = '0;
          prev_d       = '0;
          ever_high_d  = '0;
          sig_d        = '0;
          zero_alarm_d = 1'b0;
        end
      end
      CAPTURE: begin
        sig_d       = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(y_in);
        ever_high_d = ever_high_q | y_in;
        cyc_idx_d   = cyc_idx_q + CNT_W'(1);
        push        = (y_in != prev_q);
        prev_d      = y_in;
        if (y_in == '0) begin
          if (zero_run_q != '1) zero_run_d = zero_run_q + CNT_W'(1);
        end else begin
          zero_run_d = '0;
        end
        if (zero_run_d >= CNT_W'(ZERO_LIMIT)) zero_alarm_d = 1'b1;
        if (cyc_idx_q == win_len_q - CNT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (push && fifo_full && !pop) evt_ovf_d = 1'b1;

    // Clear beats start and any capture activity in the same cycle.
    if (clear) begin
      state_d      = IDLE;
      win_len_d    = '0;
      cyc_idx_d    = '0;
      zero_run_d   = '0;
      prev_d       = '0;
      ever_high_d  = '0;
      sig_d        = '0;
      zero_alarm_d = 1'b0;
      evt_ovf_d    = 1'b0;
      push         = 1'b0;
      flush        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_len_q    <= '0;
      cyc_idx_q    <= '0;
      zero_run_q   <= '0;
      prev_q       <= '0;
      ever_high_q  <= '0;
      sig_q        <= '0;
      zero_alarm_q <= 1'b0;
      evt_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      cyc_idx_q    <= cyc_idx_d;
      zero_run_q   <= zero_run_d;
      prev_q       <= prev_d;
      ever_high_q  <= ever_high_d;
      sig_q        <= sig_d;
      zero_alarm_q <= zero_alarm_d;
      evt_ovf_q    <= evt_ovf_d;
      busy_q       <= (state_d == CAPTURE);
      done_q       <= (state_d == DONE);
    end
  end

  e10_evt_fifo #(
    .W     (CNT_W + Y_W),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({cyc_idx_q, y_in}),
    .data_o  (evt_data),
    .valid_o (evt_valid),
    .full_o  (fifo_full),
    .count_o (evt_count)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign ever_high  = ever_high_q;
  assign zero_alarm = zero_alarm_q;
  assign evt_ovf    = evt_ovf_q;
endmodule

// File: tb/tb_e10_resp_monitor.sv
// Self-checking bench for e10_resp_monitor: directed scenarios plus random
// traffic, compared every cycle against a window/queue-level reference model.
module tb_e10_resp_monitor;
  import e10_mon_pkg::*;

  localparam logic [15:0] P = 16'h1021;

  logic        clk = 1'b0;
  logic        rst, start, clear, evt_ready;
  logic [12:0] y_in;
  logic [15:0] win_len;
  logic        busy, done, zero_alarm, evt_valid, evt_ovf;
  logic [15:0] signature;
  logic [12:0] ever_high;
  logic [28:0] evt_data;
  logic [3:0]  evt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e10_resp_monitor dut (
    .clk(clk), .rst(rst), .y_in(y_in), .start(start), .clear(clear),
    .win_len(win_len), .busy(busy), .done(done), .signature(signature),
    .ever_high(ever_high), .zero_alarm(zero_alarm), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .evt_ovf(evt_ovf),
    .evt_count(evt_count)
  );

  // Reference model: mode 0=idle, 1=capturing, 2=done
  int          m_mode, m_win, m_n, m_zrun;
  logic [15:0] m_sig;
  logic [12:0] m_eh, m_prev;
  bit          m_za, m_ovf;
  logic [28:0] m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_mode = 0; m_win = 0; m_n = 0; m_zrun = 0;
    m_sig = '0; m_eh = '0; m_prev = '0; m_za = 0;
  endtask

  task automatic model_step();
    bit do_pop, do_push;
    logic [28:0] ent;
    if (rst) begin
      model_zero(); m_ovf = 0; m_q.delete(); return;
    end
    if (clear) begin
      model_zero(); m_ovf = 0; m_q.delete(); return;
    end
    do_pop  = (m_q.size() != 0) && evt_ready;
    do_push = 0;
    ent     = '0;
    if (m_mode != 1) begin
      if (start) begin
        model_zero();
        m_win  = int'(win_len);
        m_mode = (m_win == 0) ? 2 : 1;
      end
    end else begin
      m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? P : 16'h0) ^ {3'b0, y_in};
      m_eh  = m_eh | y_in;
      if (y_in != m_prev) begin
        do_push = 1;
        ent = {16'(m_n), y_in};
      end
      m_prev = y_in;
      if (y_in == 0) begin
        if (m_zrun < 65535) m_zrun++;
      end else m_zrun = 0;
      if (m_zrun >= 8) m_za = 1;
      m_n++;
      if (m_n == m_win) m_mode = 2;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < 8) m_q.push_back(ent);
      else m_ovf = 1;
    end
  endtask

  task automatic compare();
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("signature", 32'(signature), 32'(m_sig));
    chk("ever_high", 32'(ever_high), 32'(m_eh));
    chk("zero_alarm", 32'(zero_alarm), 32'(m_za));
    chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
    chk("evt_count", 32'(evt_count), 32'(m_q.size()));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] wl);
    start = 1'b1; win_len = wl;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  evt_t e;

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; evt_ready = 1'b0;
    y_in = '0; win_len = '0;
    model_zero(); m_ovf = 0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_count", 32'(evt_count), 32'd0);

    // 1: all-zero window of 4
    do_start(16'd4);
    repeat (4) cycle();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_sig", 32'(signature), 32'h0);
    chk("t1_eh", 32'(ever_high), 32'h0);
    chk("t1_count", 32'(evt_count), 32'd0);
    chk("t1_za", 32'(zero_alarm), 32'd0);

    // 2: single sample of 1
    do_start(16'd1);
    y_in = 13'h0001;
    cycle();
    y_in = '0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_sig", 32'(signature), 32'h0001);
    chk("t2_eh", 32'(ever_high), 32'h0001);
    chk("t2_count", 32'(evt_count), 32'd1);
    chk("t2_evt", 32'(evt_data), 32'h0000_0001);

    // 3: zero-run watchdog raises at sample 8, fresh start drops it
    do_clear();
    do_start(16'd12);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("t3_za", 32'(zero_alarm), 32'(k >= 8));
    end
    do_start(16'd2);
    chk("t3_za_restart", 32'(zero_alarm), 32'd0);
    y_in = 13'h0003;
    repeat (2) cycle();

    // 4: toggling with consumer stalled -> overflow, then ordered drain
    do_clear();
    do_start(16'd12);
    for (int k = 0; k < 12; k++) begin
      y_in = (k % 2 == 0) ? 13'h1555 : 13'h0000;
      cycle();
    end
    chk("t4_count", 32'(evt_count), 32'd8);
    chk("t4_ovf", 32'(evt_ovf), 32'd1);
    for (int j = 0; j < 8; j++) begin
      e = evt_t'(evt_data);
      chk("t4_order", 32'(e.cyc_idx), 32'(j));
      evt_ready = 1'b1;
      cycle();
    end
    evt_ready = 1'b0;
    chk("t4_empty", 32'(evt_valid), 32'd0);

    // 5: full FIFO with simultaneous pop and push does not overflow
    do_clear();
    do_start(16'd20);
    for (int k = 0; k < 12; k++) begin
      y_in = (k % 2 == 0) ? 13'h0aaa : 13'h0001;
      evt_ready = (k >= 8);
      cycle();
    end
    evt_ready = 1'b0;
    chk("t5_count", 32'(evt_count), 32'd8);
    chk("t5_ovf", 32'(evt_ovf), 32'd0);

    // 6: async reset mid-window, then zero-length window
    do_clear();
    do_start(16'd10);
    for (int k = 0; k < 3; k++) begin
      y_in = 13'(k + 5);
      cycle();
    end
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sig", 32'(signature), 32'd0);
    chk("t6_count", 32'(evt_count), 32'd0);
    chk("t6_eh", 32'(ever_high), 32'd0);
    cycle();
    rst = 1'b0;
    do_start(16'd0);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_sig0", 32'(signature), 32'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 2));
      if (r == 0) y_in = '0;
      else if (r == 2) y_in = 13'($urandom);
      start     = ($urandom_range(0, 11) == 0);
      win_len   = 16'($urandom_range(0, 20));
      clear     = ($urandom_range(0, 79) == 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0; clear = 1'b0; evt_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
